axi_frame_reader: RTL and testbench
===================================

// Module: axi_frame_reader
// PURPOSE
//  AXI4 burst-read master fetching a rectangular frame (num_lines x line_beats words, line pitch
//  stride bytes) from AXI memory (axi_ram) and emitting it as AXI-Stream to the rectify pipeline.
//  Generalises the single fixed read: programmable geometry, auto-split bursts, internal FIFO,
//  tlast per line, tuser at frame start, sticky error reporting.
// PARAMETERS
//  DATA_WIDTH     32  AXI/AXIS data width, bits (power of 2, >=8)
//  ADDR_WIDTH     16  AXI address width
//  ID_WIDTH        8  AXI ID width; arid driven constant 0
//  MAX_BURST     16   max beats per AR burst (1..256, power of 2)
//  FIFO_DEPTH    32   read-data FIFO entries (power of 2, >= MAX_BURST)
//  CNT_WIDTH     12   width of line_beats / num_lines counters
// PORTS
//  clk            in   1           clock
//  rst            in   1           async reset, active-low
//  start          in   1           1-cycle pulse, sampled only in IDLE
//  base_addr      in   ADDR_WIDTH  frame start byte address, DATA_WIDTH/8 aligned
//  stride         in   ADDR_WIDTH  byte pitch between line starts
//  line_beats     in   CNT_WIDTH   words per line (0 = no-op frame)
//  num_lines      in   CNT_WIDTH   lines per frame (0 = no-op frame)
//  busy           out  1           high from accepted start until last AXIS beat accepted
//  done           out  1           1-cycle pulse after last AXIS beat accepted
//  err            out  1           sticky: any rresp!=OKAY seen; cleared by next start
//  m_axi_ar*      out  -           araddr[ADDR_WIDTH], arlen[8], arsize=log2(DATA_WIDTH/8),
//                                  arburst=INCR, arid=0, arvalid; arready in
//  m_axi_r*       in   -           rdata[DATA_WIDTH], rresp[2], rlast, rvalid; rready out
//  m_axis_tdata   out  DATA_WIDTH  stream data
//  m_axis_tvalid  out  1           stream valid
//  m_axis_tready  in   1           stream ready
//  m_axis_tlast   out  1           last word of each line
//  m_axis_tuser   out  1           first word of frame
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, FIFO empty, counters 0; reset mid-frame aborts, no done.
//  Config latched on accepted start; later changes ignored until next frame.
//  FSM: IDLE -start-> CALC (or DONE if line_beats==0 or num_lines==0, done pulses, no AXI traffic)
//   CALC: len = min(beats left in line, MAX_BURST, beats to next 4KB boundary); -> ADDR when
//         FIFO free entries >= len (credit counts in-flight beats), else wait in CALC.
//   ADDR: arvalid=1, address/len stable until arready; -> DATA.
//   DATA: rready=1; push each rvalid beat; on rlast advance; line done -> addr=line_start+stride;
//         more beats/lines -> CALC; else -> DRAIN.
//   DRAIN: wait FIFO empty and last beat accepted -> DONE (done=1 one cycle, busy=0) -> IDLE.
//  One outstanding burst; CALC->ADDR 1 cycle; first AR >= 2 cycles after start.
//  Line address wraps modulo 2^ADDR_WIDTH; no bounds check.
//  rvalid with rlast mismatched against len: count own beats, ignore rlast value.
//  FIFO: first-word fall-through, tvalid = !empty; tlast/tuser stored per entry; FIFO never
//   overflows (credit); push and pop same cycle when full/empty legal.
//  AXIS held stable while tvalid && !tready. Data with rresp error still forwarded; err set.
//  start during busy ignored.
// TESTING
//  T1 base=4,line_beats=4,num_lines=1,stride=0 -> one AR arlen=3 addr=4; 4 beats, tlast beat 4,
//     tuser beat 1, done once.
//  T2 line_beats=40,MAX_BURST=16 -> per line ARs len 16,16,8 (arlen 15,15,7); tlast every 40th.
//  T3 base=0xFFC0 (32b),line_beats=32 -> split at 4KB/64KB: first AR 16 beats @0xFFC0, next wraps.
//  T4 num_lines=3,stride=0x100,tready toggling 1/0 -> lines from 0,0x100,0x200; no lost/dup words.
//  T5 tready=0 throughout, 64-beat frame -> at most FIFO_DEPTH beats fetched, AR stalls in CALC.
//  T6 rresp=SLVERR on one beat -> err=1 sticky, frame completes; next start clears err; reset
//     mid-DATA -> outputs 0, no done.

Source files
------------

// File: rtl/axi_frame_reader.sv
// AXI4 burst-read frame fetcher: reads num_lines x line_beats words at a byte pitch
// of stride and replays them as AXI-Stream with tlast per line and tuser on frame start.
module axi_frame_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 8,
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 32,
  parameter int CNT_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] stride,
  input  logic [CNT_WIDTH-1:0]  line_beats,
  input  logic [CNT_WIDTH-1:0]  num_lines,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SIZE  = $clog2(BYTES);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int PW    = PTR_W + 1;
  localparam int LW    = (CNT_WIDTH > 13) ? CNT_WIDTH + 1 : 14;
  localparam int BL_W  = $clog2(MAX_BURST) + 1;
  localparam int EW    = DATA_WIDTH + 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_ADDR,
    S_DATA,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [ADDR_WIDTH-1:0] stride_q;
  logic [CNT_WIDTH-1:0]  line_beats_q;
  logic [ADDR_WIDTH-1:0] line_start;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH-1:0] next_line;
  logic [CNT_WIDTH-1:0]  beats_left;
  logic [CNT_WIDTH-1:0]  lines_left;
  logic [BL_W-1:0]       burst_len;
  logic [BL_W-1:0]       beat_cnt;
  logic [BL_W-1:0]       arlen_w;
  logic                  first_q;
  logic                  err_q;

  logic [12:0]           to_4k_bytes;
  logic [LW-1:0]         to_4k_beats;
  logic [LW-1:0]         len_c;
  logic [LW-1:0]         free_c;

  logic [EW-1:0]         mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [PW-1:0]         fifo_count;
  logic [EW-1:0]         rd_entry;
  logic                  fifo_empty;

  logic start_ok, ar_fire, r_fire, push, pop;
  logic last_in_burst, line_end, frame_end, zero_frame;
  logic unused_rlast;

  // Burst length is counted locally; rlast from the slave carries no authority.
  assign unused_rlast = m_axi_rlast;

  assign start_ok      = (state == S_IDLE) && start;
  assign zero_frame    = (line_beats == '0) || (num_lines == '0);
  assign ar_fire       = m_axi_arvalid && m_axi_arready;
  assign r_fire        = m_axi_rvalid && m_axi_rready;
  assign arlen_w       = burst_len - BL_W'(1);
  assign last_in_burst = (beat_cnt == arlen_w);
  assign line_end      = (beats_left == CNT_WIDTH'(1));
  assign frame_end     = line_end && (lines_left == CNT_WIDTH'(1));
  assign next_line     = line_start + stride_q;

  assign fifo_count = wr_ptr - rd_ptr;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign free_c     = LW'(FIFO_DEPTH) - LW'(fifo_count);
  assign push       = r_fire;
  assign pop        = m_axis_tvalid && m_axis_tready;

  // Beats remaining before the next 4KB page; a burst may never cross it.
  assign to_4k_bytes = 13'h1000 - {1'b0, cur_addr[11:0]};
  assign to_4k_beats = LW'(to_4k_bytes >> SIZE);

  always_comb begin
    len_c = LW'(beats_left);
    if (len_c > LW'(MAX_BURST)) len_c = LW'(MAX_BURST);
    if (len_c > to_4k_beats)    len_c = to_4k_beats;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start) state_nx = zero_frame ? S_DONE : S_CALC;
      S_CALC:  if (free_c >= len_c) state_nx = S_ADDR;
      S_ADDR:  if (ar_fire) state_nx = S_DATA;
      S_DATA:  if (r_fire && last_in_burst) state_nx = frame_end ? S_DRAIN : S_CALC;
      S_DRAIN: if (fifo_empty) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stride_q     <= '0;
      line_beats_q <= '0;
      line_start   <= '0;
      cur_addr     <= '0;
      beats_left   <= '0;
      lines_left   <= '0;
      burst_len    <= '0;
      beat_cnt     <= '0;
      first_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      if (start_ok) begin
        stride_q     <= stride;
        line_beats_q <= line_beats;
        line_start   <= base_addr;
        cur_addr     <= base_addr;
        beats_left   <= line_beats;
        lines_left   <= num_lines;
        first_q      <= 1'b1;
        err_q        <= 1'b0;
      end
      if (state == S_CALC) begin
        burst_len <= len_c[BL_W-1:0];
        beat_cnt  <= '0;
      end
      if (r_fire) begin
        beat_cnt <= beat_cnt + BL_W'(1);
        first_q  <= 1'b0;
        if (m_axi_rresp != 2'b00) err_q <= 1'b1;
        if (line_end) begin
          if (!frame_end) begin
            lines_left <= lines_left - CNT_WIDTH'(1);
            beats_left <= line_beats_q;
            line_start <= next_line;
            cur_addr   <= next_line;
          end
        end else begin
          beats_left <= beats_left - CNT_WIDTH'(1);
          cur_addr   <= cur_addr + ADDR_WIDTH'(BYTES);
        end
      end
    end
  end

  // Read-data FIFO, first-word fall-through; entries carry {tuser, tlast, data}.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= {first_q, line_end, m_axi_rdata};
  end

  assign rd_entry = mem[rd_ptr[PTR_W-1:0]];

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_empty ? '0 : rd_entry[DATA_WIDTH-1:0];
  assign m_axis_tlast  = !fifo_empty && rd_entry[DATA_WIDTH];
  assign m_axis_tuser  = !fifo_empty && rd_entry[DATA_WIDTH+1];

  assign m_axi_arvalid = (state == S_ADDR);
  assign m_axi_araddr  = m_axi_arvalid ? cur_addr : '0;
  assign m_axi_arlen   = m_axi_arvalid ? 8'(arlen_w) : '0;
  assign m_axi_arsize  = m_axi_arvalid ? 3'(SIZE) : '0;
  assign m_axi_arburst = m_axi_arvalid ? 2'b01 : '0;
  assign m_axi_arid    = '0;
  assign m_axi_rready  = (state == S_DATA);

  assign busy = (state == S_CALC) || (state == S_ADDR) || (state == S_DATA) || (state == S_DRAIN);
  assign done = (state == S_DONE);
  assign err  = err_q;

endmodule

// File: tb/tb_axi_frame_reader.sv
// Bench for axi_frame_reader: AXI memory slave plus AXIS sink, compared against a
// frame-level model that derives bursts and stream words directly from the geometry.
module tb_axi_frame_reader;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int IW = 8;
  localparam int MB = 16;
  localparam int FD = 32;
  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] stride = '0;
  logic [CW-1:0] line_beats = '0;
  logic [CW-1:0] num_lines = '0;
  logic          busy, done, err;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic [IW-1:0] arid;
  logic          arvalid;
  logic          arready = 1'b0;
  logic [DW-1:0] rdata = '0;
  logic [1:0]    rresp = '0;
  logic          rlast = 1'b0;
  logic          rvalid = 1'b0;
  logic          rready;
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready = 1'b0;
  logic          tlast, tuser;

  axi_frame_reader #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW),
    .MAX_BURST(MB), .FIFO_DEPTH(FD), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .base_addr(base_addr), .stride(stride), .line_beats(line_beats), .num_lines(num_lines),
    .busy(busy), .done(done), .err(err),
    .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
    .m_axi_arburst(arburst), .m_axi_arid(arid), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast), .m_axi_rvalid(rvalid),
    .m_axi_rready(rready),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .m_axis_tlast(tlast), .m_axis_tuser(tuser)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] base;
    logic [15:0] stride;
    int lb;
    int nl;
    int mode;
    int eidx;
    int exp_ar;
    int exp_beats;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int cur_tag = 0;

  // Slave / sink state shared with the stimulus process.
  logic [15:0] q_addr[$];
  int          q_len[$];
  int          r_beat = 0;
  int          r_total = 0;
  int          err_idx = -1;
  int          tmode = 0;
  bit          hold = 1'b0;
  int          done_cnt = 0;
  int          attr_bad = 0;
  logic [15:0] ar_log_a[$];
  int          ar_log_l[$];
  logic [33:0] got[$];

  function automatic logic [31:0] memf(input logic [15:0] a);
    return {a ^ 16'hC3A5, a + 16'h1234};
  endfunction

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL frame%0d %s actual=%0d required=%0d", cur_tag, nm, act, exp);
    end
  endtask

  // Drive slave/sink at the falling edge; handshakes seen here complete at the next rise.
  always @(negedge clk) begin
    logic [15:0] a;
    if (!rst) begin
      q_addr.delete();
      q_len.delete();
      r_beat  = 0;
      arready = 1'b0;
      rvalid  = 1'b0;
      rdata   = '0;
      rresp   = 2'b00;
      rlast   = 1'b0;
      tready  = 1'b0;
    end else begin
      if (done) done_cnt++;
      arready = ($urandom_range(0, 3) != 0);
      if (q_addr.size() > 0 && $urandom_range(0, 4) != 0) begin
        a      = 16'(q_addr[0] + 16'(r_beat * 4));
        rvalid = 1'b1;
        rdata  = memf(a);
        rlast  = (r_beat == q_len[0]);
        rresp  = (r_total == err_idx) ? 2'b10 : 2'b00;
      end else begin
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
      end
      case (tmode)
        0:       tready = 1'b1;
        1:       tready = ~tready;
        2:       tready = ($urandom_range(0, 2) != 0);
        default: tready = !hold;
      endcase
      if (arvalid && arready) begin
        ar_log_a.push_back(araddr);
        ar_log_l.push_back(int'(arlen));
        q_addr.push_back(araddr);
        q_len.push_back(int'(arlen));
        if (arsize != 3'd2 || arburst != 2'b01 || arid != '0) attr_bad++;
      end
      if (rvalid && rready && q_addr.size() > 0) begin
        r_total++;
        r_beat++;
        if (r_beat > q_len[0]) begin
          void'(q_addr.pop_front());
          void'(q_len.pop_front());
          r_beat = 0;
        end
      end
      if (tvalid && tready) got.push_back({tuser, tlast, tdata});
    end
  end

  task automatic run_frame(input int tag, input logic [15:0] base, input logic [15:0] strd,
                           input int lb, input int nl, input int mode, input int eidx,
                           input int exp_ar, input int exp_beats);
    logic [15:0] m_ar_a[$];
    int          m_ar_l[$];
    logic [33:0] m_beat[$];
    logic [15:0] ls, a;
    int          rem, n, to4k, n_bad;
    bit          noop, got_done;
    cur_tag = tag;
    noop = (lb == 0 || nl == 0);
    for (int l = 0; l < nl; l++) begin
      ls  = 16'(base + l * strd);
      a   = ls;
      rem = lb;
      while (rem > 0) begin
        to4k = (4096 - (int'(a) % 4096)) / 4;
        n = rem;
        if (n > MB)   n = MB;
        if (n > to4k) n = to4k;
        m_ar_a.push_back(a);
        m_ar_l.push_back(n - 1);
        a = 16'(a + 4 * n);
        rem -= n;
      end
      for (int b = 0; b < lb; b++)
        m_beat.push_back({(l == 0 && b == 0), (b == lb - 1), memf(16'(ls + 4 * b))});
    end
    if (exp_ar < 0)    exp_ar = m_ar_a.size();
    if (exp_beats < 0) exp_beats = m_beat.size();

    @(negedge clk); #1;
    ar_log_a.delete(); ar_log_l.delete(); got.delete();
    done_cnt = 0; r_total = 0; attr_bad = 0;
    err_idx = eidx; tmode = mode; hold = (mode == 3);
    base_addr = base; stride = strd; line_beats = CW'(lb); num_lines = CW'(nl);
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    check("err_cleared_on_start", err, 0);
    check("busy_done_after_start", {busy, done}, noop ? 2'b01 : 2'b10);
    base_addr = 16'($urandom); stride = 16'($urandom);
    line_beats = CW'($urandom); num_lines = CW'($urandom);
    repeat (3) @(negedge clk);
    #1;
    if (busy) begin
      start = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
    end
    if (mode == 3) begin
      repeat (200) @(negedge clk);
      #1;
      check("stall_fetched_beats", r_total, FD);
      check("stall_ar_count", ar_log_a.size(), 2);
      hold = 1'b0;
    end
    got_done = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (done_cnt > 0) begin
        got_done = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
    check("done_seen", got_done, 1);
    repeat (4) @(negedge clk);
    #1;
    check("done_pulses", done_cnt, 1);
    check("busy_after_done", busy, 0);
    check("ar_count_table", ar_log_a.size(), exp_ar);
    check("ar_count_model", ar_log_a.size(), m_ar_a.size());
    n_bad = 0;
    for (int i = 0; i < ar_log_a.size() && i < m_ar_a.size(); i++)
      if (ar_log_a[i] !== m_ar_a[i] || ar_log_l[i] != m_ar_l[i]) n_bad++;
    check("ar_addr_len", n_bad, 0);
    check("ar_attrs", attr_bad, 0);
    check("beat_count", got.size(), exp_beats);
    n_bad = 0;
    for (int i = 0; i < got.size() && i < m_beat.size(); i++)
      if (got[i] !== m_beat[i]) n_bad++;
    check("stream_words", n_bad, 0);
    check("err_final", err, (eidx >= 0 && eidx < lb * nl) ? 1 : 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[9];
    bit   reached;
    int   lb, nl, eidx, mode;
    logic [15:0] base, strd;

    vt[0] = '{16'h0004, 16'h0000,  4, 1, 0, -1, 1,  4};
    vt[1] = '{16'h0000, 16'h0100, 40, 2, 2, -1, 6, 80};
    vt[2] = '{16'hFFC0, 16'h0000, 32, 1, 0, -1, 2, 32};
    vt[3] = '{16'h0000, 16'h0100,  8, 3, 1, -1, 3, 24};
    vt[4] = '{16'h1000, 16'h0000, 64, 1, 3, -1, 4, 64};
    vt[5] = '{16'h0200, 16'h0040, 10, 2, 2,  7, 2, 20};
    vt[6] = '{16'h0000, 16'h0010,  0, 3, 0, -1, 0,  0};
    vt[7] = '{16'h0040, 16'h0010,  5, 0, 0, -1, 0,  0};
    vt[8] = '{16'h0300, 16'h0000,  3, 1, 0, -1, 1,  3};

    repeat (3) @(negedge clk);
    #1;
    check("reset_ctrl", {arvalid, rready, tvalid, busy, done, err, tlast, tuser}, 0);
    check("reset_tdata", tdata, 0);
    check("reset_ar_bus", {araddr, arlen}, 0);
    rst = 1'b1;

    for (int i = 0; i < 9; i++)
      run_frame(i, vt[i].base, vt[i].stride, vt[i].lb, vt[i].nl, vt[i].mode,
                vt[i].eidx, vt[i].exp_ar, vt[i].exp_beats);

    // Abort a frame with reset partway through the data phase.
    cur_tag = 100;
    @(negedge clk); #1;
    err_idx = 2; tmode = 0; r_total = 0;
    base_addr = 16'h0400; stride = 16'h0100; line_beats = CW'(64); num_lines = CW'(2);
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (r_total >= 5) begin
        reached = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
    check("abort_reached_data", reached, 1);
    check("abort_err_before_reset", err, 1);
    rst = 1'b0;
    #1;
    check("abort_outputs_zero", {arvalid, rready, tvalid, busy, done, err, tlast, tuser}, 0);
    check("abort_tdata_zero", tdata, 0);
    done_cnt = 0;
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    check("abort_no_done", done_cnt, 0);
    check("abort_idle", {busy, err}, 0);
    run_frame(101, 16'h0080, 16'h0020, 6, 2, 2, -1, 2, 12);

    for (int k = 0; k < 6; k++) begin
      lb   = $urandom_range(1, 50);
      nl   = $urandom_range(1, 4);
      mode = $urandom_range(0, 2);
      strd = 16'($urandom) & 16'hFFFC;
      if ($urandom_range(0, 1) == 0) base = 16'($urandom) & 16'hFFFC;
      else base = {4'($urandom), 12'hF00 | 12'($urandom_range(0, 63) * 4)};
      eidx = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(0, lb * nl - 1);
      run_frame(200 + k, base, strd, lb, nl, mode, eidx, -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
